// File: rtl/egress_ptp_pkg.sv
// rtl/egress_ptp_pkg.sv - shared constants and parameter checks for the egress PTP tag tracker
package egress_ptp_pkg;

    localparam int TS_W = 80;

    typedef enum logic {
        TS_OK      = 1'b0,
        TS_TIMEOUT = 1'b1
    } ts_status_e;

    function automatic bit is_legal_stream_width(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

    function automatic bit tag_width_ok(input int tag_w, input int depth);
        return (1 << tag_w) >= depth;
    endfunction

endpackage

// File: rtl/ptp_tag_fifo.sv
// rtl/ptp_tag_fifo.sv - in-order FIFO of outstanding timestamp tags
module ptp_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [TAG_W-1:0]           push_tag_i,
    input  logic                       pop_i,
    output logic [TAG_W-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guards keep the FIFO consistent even if a caller misbehaves at the limits.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
    end

endmodule

// File: rtl/egress_ptp_tag_tracker.sv
// rtl/egress_ptp_tag_tracker.sv - tags timestamp-requesting TX frames and pairs them with MAC timestamps
module egress_ptp_tag_tracker
    import egress_ptp_pkg::*;
#(
    parameter int STREAM_WIDTH = 64,
    parameter int DEPTH        = 8,
    parameter int TAG_W        = 4,
    parameter int TO_W         = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [STREAM_WIDTH*8-1:0] usr_s_axis_tdata,
    input  logic [STREAM_WIDTH-1:0]   usr_s_axis_tkeep,
    input  logic                      usr_s_axis_tlast,
    input  logic                      usr_s_axis_tuser,
    input  logic                      usr_s_axis_tvalid,
    output logic                      usr_s_axis_tready,
    output logic [STREAM_WIDTH*8-1:0] mac_m_axis_tdata,
    output logic [STREAM_WIDTH-1:0]   mac_m_axis_tkeep,
    output logic                      mac_m_axis_tlast,
    output logic [1:0]                mac_m_axis_tuser,
    output logic [TAG_W-1:0]          mac_m_axis_ttag,
    output logic                      mac_m_axis_tvalid,
    input  logic                      mac_m_axis_tready,
    input  logic [TS_W-1:0]           tx_ptp_tstamp_tdata,
    input  logic [TAG_W-1:0]          tx_ptp_tstamp_ttag,
    input  logic                      tx_ptp_tstamp_tvalid,
    output logic                      tx_ptp_tstamp_tready,
    output logic [TS_W-1:0]           ts_m_axis_tdata,
    output logic [TAG_W-1:0]          ts_m_axis_ttag,
    output logic                      ts_m_axis_tstatus,
    output logic                      ts_m_axis_tvalid,
    input  logic                      ts_m_axis_tready,
    input  logic [TO_W-1:0]           timeout_cycles,
    input  logic                      cnt_clear,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic [15:0]               mismatch_cnt,
    output logic [15:0]               timeout_cnt
);

    generate
        if (!is_legal_stream_width(STREAM_WIDTH)) begin : g_bad_stream_width
            $error("egress_ptp_tag_tracker: STREAM_WIDTH must be 8, 16, 32 or 64");
        end
        if ((DEPTH < 2) || (DEPTH > 32) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("egress_ptp_tag_tracker: DEPTH must be a power of 2 in 2..32");
        end
        if (!tag_width_ok(TAG_W, DEPTH)) begin : g_bad_tag_w
            $error("egress_ptp_tag_tracker: 2**TAG_W must be >= DEPTH");
        end
    endgenerate

    logic             in_frame_q, in_frame_d;
    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    logic [TAG_W-1:0] frame_tag_q, frame_tag_d;
    logic [TO_W-1:0]  head_age_q, head_age_d;
    logic [15:0]      mismatch_cnt_q, mismatch_cnt_d;
    logic [15:0]      timeout_cnt_q, timeout_cnt_d;
    logic             ts_valid_q, ts_valid_d;
    logic [TS_W-1:0]  ts_data_q, ts_data_d;
    logic [TAG_W-1:0] ts_tag_q, ts_tag_d;
    ts_status_e       ts_status_q, ts_status_d;

    logic             sof, gate, usr_hs, push, pop;
    logic             fifo_full, fifo_empty;
    logic [TAG_W-1:0] head_tag;
    logic             can_accept, match, mismatch, timeout_fire;

    assign sof    = ~in_frame_q;
    assign gate   = sof & usr_s_axis_tuser & fifo_full;
    assign usr_hs = usr_s_axis_tvalid & usr_s_axis_tready;
    assign push   = usr_hs & sof & usr_s_axis_tuser;

    assign usr_s_axis_tready = mac_m_axis_tready & ~gate;
    assign mac_m_axis_tvalid = usr_s_axis_tvalid & ~gate;
    assign mac_m_axis_tdata  = usr_s_axis_tdata;
    assign mac_m_axis_tkeep  = usr_s_axis_tkeep;
    assign mac_m_axis_tlast  = usr_s_axis_tlast;
    assign mac_m_axis_tuser  = {1'b0, sof & usr_s_axis_tuser};
    // On the first beat the tag is not latched yet, so show the live counter.
    assign mac_m_axis_ttag   = sof ? next_tag_q : frame_tag_q;

    ptp_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (push),
        .push_tag_i (next_tag_q),
        .pop_i      (pop),
        .head_o     (head_tag),
        .count_o    (outstanding),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign can_accept   = ~ts_valid_q | ts_m_axis_tready;
    assign match        = tx_ptp_tstamp_tvalid & ~fifo_empty &
                          (tx_ptp_tstamp_ttag == head_tag) & can_accept;
    assign mismatch     = tx_ptp_tstamp_tvalid & (fifo_empty | (tx_ptp_tstamp_ttag != head_tag));
    assign timeout_fire = (timeout_cycles != '0) & ~fifo_empty &
                          (head_age_q >= timeout_cycles) & can_accept & ~match;
    assign pop          = match | timeout_fire;

    assign tx_ptp_tstamp_tready = match | mismatch;

    always_comb begin
        in_frame_d  = in_frame_q;
        frame_tag_d = frame_tag_q;
        next_tag_d  = next_tag_q;
        if (usr_hs) in_frame_d = ~usr_s_axis_tlast;
        if (usr_hs & sof) frame_tag_d = next_tag_q;
        if (push) next_tag_d = next_tag_q + 1'b1;

        if (pop)
            head_age_d = '0;
        else if (!fifo_empty)
            head_age_d = (head_age_q == {TO_W{1'b1}}) ? head_age_q : head_age_q + 1'b1;
        else
            head_age_d = '0;
    end

    always_comb begin
        ts_valid_d  = ts_valid_q;
        ts_data_d   = ts_data_q;
        ts_tag_d    = ts_tag_q;
        ts_status_d = ts_status_q;
        if (match) begin
            ts_valid_d  = 1'b1;
            ts_data_d   = tx_ptp_tstamp_tdata;
            ts_tag_d    = head_tag;
            ts_status_d = TS_OK;
        end else if (timeout_fire) begin
            ts_valid_d  = 1'b1;
            ts_data_d   = '0;
            ts_tag_d    = head_tag;
            ts_status_d = TS_TIMEOUT;
        end else if (ts_m_axis_tready) begin
            ts_valid_d  = 1'b0;
        end
    end

    always_comb begin
        mismatch_cnt_d = mismatch_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        if (cnt_clear) begin
            mismatch_cnt_d = '0;
            timeout_cnt_d  = '0;
        end else begin
            if (mismatch && (mismatch_cnt_q != 16'hFFFF)) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            if (timeout_fire && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_frame_q     <= 1'b0;
            next_tag_q     <= '0;
            frame_tag_q    <= '0;
            head_age_q     <= '0;
            mismatch_cnt_q <= '0;
            timeout_cnt_q  <= '0;
            ts_valid_q     <= 1'b0;
            ts_data_q      <= '0;
            ts_tag_q       <= '0;
            ts_status_q    <= TS_OK;
        end else begin
            in_frame_q     <= in_frame_d;
            next_tag_q     <= next_tag_d;
            frame_tag_q    <= frame_tag_d;
            head_age_q     <= head_age_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            ts_valid_q     <= ts_valid_d;
            ts_data_q      <= ts_data_d;
            ts_tag_q       <= ts_tag_d;
            ts_status_q    <= ts_status_d;
        end
    end

    assign ts_m_axis_tvalid  = ts_valid_q;
    assign ts_m_axis_tdata   = ts_data_q;
    assign ts_m_axis_ttag    = ts_tag_q;
    assign ts_m_axis_tstatus = ts_status_q;
    assign mismatch_cnt      = mismatch_cnt_q;
    assign timeout_cnt       = timeout_cnt_q;

endmodule

// File: tb/tb_egress_ptp_tag_tracker.sv
// tb/tb_egress_ptp_tag_tracker.sv - directed self-checking bench for egress_ptp_tag_tracker
module tb_egress_ptp_tag_tracker;

    localparam int SW    = 64;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;
    localparam int TO_W  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [SW*8-1:0]   usr_tdata;
    logic [SW-1:0]     usr_tkeep;
    logic              usr_tlast, usr_tuser, usr_tvalid, usr_tready;
    logic [SW*8-1:0]   mac_tdata;
    logic [SW-1:0]     mac_tkeep;
    logic              mac_tlast;
    logic [1:0]        mac_tuser;
    logic [TAG_W-1:0]  mac_ttag;
    logic              mac_tvalid, mac_tready;
    logic [79:0]       tst_tdata;
    logic [TAG_W-1:0]  tst_ttag;
    logic              tst_tvalid, tst_tready;
    logic [79:0]       ts_tdata;
    logic [TAG_W-1:0]  ts_ttag;
    logic              ts_tstatus, ts_tvalid, ts_tready;
    logic [TO_W-1:0]   timeout_cycles;
    logic              cnt_clear;
    logic [$clog2(DEPTH):0] outstanding;
    logic [15:0]       mismatch_cnt, timeout_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    egress_ptp_tag_tracker #(
        .STREAM_WIDTH (SW),
        .DEPTH        (DEPTH),
        .TAG_W        (TAG_W),
        .TO_W         (TO_W)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .usr_s_axis_tdata     (usr_tdata),
        .usr_s_axis_tkeep     (usr_tkeep),
        .usr_s_axis_tlast     (usr_tlast),
        .usr_s_axis_tuser     (usr_tuser),
        .usr_s_axis_tvalid    (usr_tvalid),
        .usr_s_axis_tready    (usr_tready),
        .mac_m_axis_tdata     (mac_tdata),
        .mac_m_axis_tkeep     (mac_tkeep),
        .mac_m_axis_tlast     (mac_tlast),
        .mac_m_axis_tuser     (mac_tuser),
        .mac_m_axis_ttag      (mac_ttag),
        .mac_m_axis_tvalid    (mac_tvalid),
        .mac_m_axis_tready    (mac_tready),
        .tx_ptp_tstamp_tdata  (tst_tdata),
        .tx_ptp_tstamp_ttag   (tst_ttag),
        .tx_ptp_tstamp_tvalid (tst_tvalid),
        .tx_ptp_tstamp_tready (tst_tready),
        .ts_m_axis_tdata      (ts_tdata),
        .ts_m_axis_ttag       (ts_ttag),
        .ts_m_axis_tstatus    (ts_tstatus),
        .ts_m_axis_tvalid     (ts_tvalid),
        .ts_m_axis_tready     (ts_tready),
        .timeout_cycles       (timeout_cycles),
        .cnt_clear            (cnt_clear),
        .outstanding          (outstanding),
        .mismatch_cnt         (mismatch_cnt),
        .timeout_cnt          (timeout_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic req, input int beats);
        for (int b = 0; b < beats; b++) begin
            int n;
            n = 0;
            usr_tvalid = 1'b1;
            usr_tuser  = req;
            usr_tlast  = (b == beats - 1);
            usr_tdata  = (SW*8)'(b + 1);
            #1;
            while (!usr_tready && n < 50) begin
                step();
                n++;
            end
            checks++;
            if (n >= 50) begin
                failures++;
                $display("FAIL send_frame_wait: usr_tready stayed %0b for %0d cycles, required 1", usr_tready, n);
            end
            step();
        end
        usr_tvalid = 1'b0;
        usr_tlast  = 1'b0;
        usr_tuser  = 1'b0;
    endtask

    task automatic send_ret(input logic [TAG_W-1:0] tag, input logic [79:0] data);
        int n;
        n = 0;
        tst_tvalid = 1'b1;
        tst_ttag   = tag;
        tst_tdata  = data;
        #1;
        while (!tst_tready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_ret_wait: tstamp_tready stayed %0b for %0d cycles, required 1", tst_tready, n);
        end
        step();
        tst_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        usr_tdata = '0; usr_tkeep = '1; usr_tlast = 0; usr_tuser = 0; usr_tvalid = 0;
        mac_tready = 0; tst_tdata = '0; tst_ttag = '0; tst_tvalid = 0; ts_tready = 0;
        timeout_cycles = '0; cnt_clear = 0;
        #3;
        checks++; if (outstanding !== 0) begin failures++; $display("FAIL reset_outstanding: got %0d required 0", outstanding); end
        checks++; if (ts_tvalid !== 1'b0) begin failures++; $display("FAIL reset_ts_tvalid: got %0b required 0", ts_tvalid); end
        checks++; if (ts_tdata !== 80'h0 || ts_ttag !== 0 || ts_tstatus !== 1'b0) begin
            failures++; $display("FAIL reset_ts_fields: got data %0h tag %0d status %0b required 0/0/0", ts_tdata, ts_ttag, ts_tstatus); end
        checks++; if (mismatch_cnt !== 0 || timeout_cnt !== 0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d required 0/0", mismatch_cnt, timeout_cnt); end
        checks++; if (mac_ttag !== 0) begin failures++; $display("FAIL reset_mac_ttag: got %0d required 0", mac_ttag); end
        step(); step();
        resetn = 1'b1;
        mac_tready = 1'b1;
        ts_tready = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [79:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            usr_tvalid = 1; usr_tuser = 1; usr_tlast = 1; usr_tdata = (SW*8)'(32'hCAFE0000 + i);
            #1;
            checks++;
            if (mac_ttag !== TAG_W'(i) || mac_tuser !== 2'b01 || mac_tvalid !== 1'b1 || usr_tready !== 1'b1) begin
                failures++;
                $display("FAIL basic_sof_%0d: ttag %0d tuser %0b mvalid %0b uready %0b required %0d/01/1/1",
                         i, mac_ttag, mac_tuser, mac_tvalid, usr_tready, i);
            end
            checks++;
            if (mac_tdata !== usr_tdata || mac_tkeep !== usr_tkeep || mac_tlast !== 1'b1) begin
                failures++; $display("FAIL basic_passthru_%0d: data/keep/last not forwarded (last %0b)", i, mac_tlast);
            end
            step();
            usr_tvalid = 0; usr_tuser = 0; usr_tlast = 0;
        end
        #1;
        checks++; if (outstanding !== 3) begin failures++; $display("FAIL basic_outstanding3: got %0d required 3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            exp_d = 80'(16 * (i + 1));
            tst_tvalid = 1; tst_ttag = TAG_W'(i); tst_tdata = exp_d;
            #1;
            checks++; if (tst_tready !== 1'b1) begin failures++; $display("FAIL basic_ret_ready_%0d: got %0b required 1", i, tst_tready); end
            step();
            tst_tvalid = 0;
            #1;
            checks++;
            if (ts_tvalid !== 1'b1 || ts_ttag !== TAG_W'(i) || ts_tdata !== exp_d || ts_tstatus !== 1'b0) begin
                failures++;
                $display("FAIL basic_ts_%0d: valid %0b tag %0d data %0h status %0b required 1/%0d/%0h/0",
                         i, ts_tvalid, ts_ttag, ts_tdata, ts_tstatus, i, exp_d);
            end
        end
        step();
        checks++; if (ts_tvalid !== 1'b0 || outstanding !== 0) begin
            failures++; $display("FAIL basic_drain: ts_tvalid %0b outstanding %0d required 0/0", ts_tvalid, outstanding); end
    endtask

    task automatic test_mismatch();
        send_frame(1'b1, 1);
        #1;
        checks++; if (outstanding !== 1) begin failures++; $display("FAIL mm_outstanding_pre: got %0d required 1", outstanding); end
        tst_tvalid = 1; tst_ttag = 4'd5; tst_tdata = 80'h55;
        #1;
        checks++; if (tst_tready !== 1'b1) begin failures++; $display("FAIL mm_drop_ready: got %0b required 1", tst_tready); end
        step();
        tst_tvalid = 0;
        #1;
        checks++; if (mismatch_cnt !== 1 || outstanding !== 1 || ts_tvalid !== 1'b0) begin
            failures++; $display("FAIL mm_after_drop: cnt %0d outstanding %0d ts_tvalid %0b required 1/1/0",
                                 mismatch_cnt, outstanding, ts_tvalid); end
        send_ret(4'd3, 80'h33);
        #1;
        checks++; if (ts_tvalid !== 1'b1 || ts_ttag !== 4'd3 || ts_tdata !== 80'h33) begin
            failures++; $display("FAIL mm_head_match: valid %0b tag %0d data %0h required 1/3/33", ts_tvalid, ts_ttag, ts_tdata); end
        cnt_clear = 1; tst_tvalid = 1; tst_ttag = 4'd9;
        step();
        cnt_clear = 0; tst_tvalid = 0;
        #1;
        checks++; if (mismatch_cnt !== 0) begin failures++; $display("FAIL mm_clear_priority: got %0d required 0", mismatch_cnt); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) send_frame(1'b1, 1);
        #1;
        checks++; if (outstanding !== 8) begin failures++; $display("FAIL full_outstanding8: got %0d required 8", outstanding); end
        usr_tvalid = 1; usr_tuser = 0; usr_tlast = 0;
        #1;
        checks++; if (usr_tready !== 1'b1 || mac_tvalid !== 1'b1 || mac_tuser !== 2'b00 || mac_ttag !== 4'd12) begin
            failures++; $display("FAIL full_nonreq_b0: uready %0b mvalid %0b tuser %0b ttag %0d required 1/1/00/12",
                                 usr_tready, mac_tvalid, mac_tuser, mac_ttag); end
        step();
        usr_tlast = 1;
        #1;
        checks++; if (usr_tready !== 1'b1 || mac_ttag !== 4'd12) begin
            failures++; $display("FAIL full_nonreq_b1: uready %0b ttag %0d required 1/12", usr_tready, mac_ttag); end
        step();
        usr_tuser = 1;
        #1;
        checks++; if (usr_tready !== 1'b0 || mac_tvalid !== 1'b0) begin
            failures++; $display("FAIL full_stall: uready %0b mvalid %0b required 0/0", usr_tready, mac_tvalid); end
        step(); step(); step();
        checks++; if (usr_tready !== 1'b0 || outstanding !== 8) begin
            failures++; $display("FAIL full_stall_hold: uready %0b outstanding %0d required 0/8", usr_tready, outstanding); end
        tst_tvalid = 1; tst_ttag = 4'd4; tst_tdata = 80'h44;
        #1;
        checks++; if (tst_tready !== 1'b1 || usr_tready !== 1'b0) begin
            failures++; $display("FAIL full_pop_cycle: tst_tready %0b uready %0b required 1/0", tst_tready, usr_tready); end
        step();
        tst_tvalid = 0;
        #1;
        checks++; if (usr_tready !== 1'b1 || mac_ttag !== 4'd12 || ts_ttag !== 4'd4) begin
            failures++; $display("FAIL full_release: uready %0b ttag %0d ts_tag %0d required 1/12/4", usr_tready, mac_ttag, ts_ttag); end
        step();
        usr_tvalid = 0; usr_tuser = 0; usr_tlast = 0;
        #1;
        checks++; if (outstanding !== 8) begin failures++; $display("FAIL full_refill: got %0d required 8", outstanding); end
        for (int t = 5; t <= 12; t++) begin
            send_ret(TAG_W'(t), 80'(t));
            #1;
            checks++; if (ts_ttag !== TAG_W'(t) || ts_tdata !== 80'(t) || ts_tvalid !== 1'b1) begin
                failures++; $display("FAIL full_drain_%0d: tag %0d data %0h valid %0b required %0d", t, ts_ttag, ts_tdata, ts_tvalid, t); end
        end
        step();
    endtask

    task automatic test_backpressure();
        ts_tready = 0;
        send_frame(1'b1, 1);
        send_frame(1'b1, 1);
        send_ret(4'd13, 80'hD0D0);
        #1;
        checks++; if (ts_tvalid !== 1'b1 || ts_ttag !== 4'd13) begin
            failures++; $display("FAIL bp_first_held: valid %0b tag %0d required 1/13", ts_tvalid, ts_ttag); end
        tst_tvalid = 1; tst_ttag = 4'd14; tst_tdata = 80'hE0E0;
        #1;
        checks++; if (tst_tready !== 1'b0) begin failures++; $display("FAIL bp_second_stalled: got %0b required 0", tst_tready); end
        step(); step();
        checks++; if (tst_tready !== 1'b0 || ts_ttag !== 4'd13 || outstanding !== 1) begin
            failures++; $display("FAIL bp_hold: tready %0b tag %0d outstanding %0d required 0/13/1", tst_tready, ts_ttag, outstanding); end
        ts_tready = 1;
        #1;
        checks++; if (tst_tready !== 1'b1 || ts_ttag !== 4'd13 || ts_tdata !== 80'hD0D0) begin
            failures++; $display("FAIL bp_release: tready %0b tag %0d data %0h required 1/13/d0d0", tst_tready, ts_ttag, ts_tdata); end
        step();
        tst_tvalid = 0;
        #1;
        checks++; if (ts_tvalid !== 1'b1 || ts_ttag !== 4'd14 || ts_tdata !== 80'hE0E0) begin
            failures++; $display("FAIL bp_second: valid %0b tag %0d data %0h required 1/14/e0e0", ts_tvalid, ts_ttag, ts_tdata); end
        step();
        checks++; if (ts_tvalid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %0b required 0", ts_tvalid); end
    endtask

    task automatic test_match_vs_timeout();
        ts_tready = 0;
        send_frame(1'b1, 1);
        send_frame(1'b1, 1);
        send_ret(4'd15, 80'hF5);
        timeout_cycles = 16'd3;
        for (int k = 0; k < 10; k++) step();
        checks++; if (ts_ttag !== 4'd15 || ts_tstatus !== 1'b0 || timeout_cnt !== 0 || outstanding !== 1) begin
            failures++; $display("FAIL mt_wait: tag %0d status %0b tcnt %0d outstanding %0d required 15/0/0/1",
                                 ts_ttag, ts_tstatus, timeout_cnt, outstanding); end
        tst_tvalid = 1; tst_ttag = 4'd0; tst_tdata = 80'hA0; ts_tready = 1;
        #1;
        checks++; if (tst_tready !== 1'b1) begin failures++; $display("FAIL mt_ready: got %0b required 1", tst_tready); end
        step();
        tst_tvalid = 0;
        #1;
        checks++; if (ts_ttag !== 4'd0 || ts_tstatus !== 1'b0 || ts_tdata !== 80'hA0 || timeout_cnt !== 0 || outstanding !== 0) begin
            failures++; $display("FAIL mt_match_wins: tag %0d status %0b data %0h tcnt %0d outstanding %0d required 0/0/a0/0/0",
                                 ts_ttag, ts_tstatus, ts_tdata, timeout_cnt, outstanding); end
        timeout_cycles = '0;
        step();
    endtask

    task automatic test_timeout();
        logic early;
        resetn = 0;
        step();
        resetn = 1;
        ts_tready = 1;
        timeout_cycles = 16'd100;
        send_frame(1'b1, 1);
        early = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (ts_tvalid) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early: fired before head_age 100 (flag %0b) required 0", early); end
        step();
        checks++; if (ts_tvalid !== 1'b1 || ts_ttag !== 4'd0 || ts_tdata !== 80'h0 || ts_tstatus !== 1'b1) begin
            failures++; $display("FAIL to_emit: valid %0b tag %0d data %0h status %0b required 1/0/0/1",
                                 ts_tvalid, ts_ttag, ts_tdata, ts_tstatus); end
        checks++; if (timeout_cnt !== 1 || outstanding !== 0) begin
            failures++; $display("FAIL to_count: tcnt %0d outstanding %0d required 1/0", timeout_cnt, outstanding); end
        timeout_cycles = '0;
        step();
        send_ret(4'd0, 80'h99);
        #1;
        checks++; if (mismatch_cnt !== 1 || ts_tvalid !== 1'b0) begin
            failures++; $display("FAIL to_late_return: mcnt %0d ts_tvalid %0b required 1/0", mismatch_cnt, ts_tvalid); end
    endtask

    task automatic test_wrap();
        logic [TAG_W-1:0] exp_t;
        for (int i = 0; i < 20; i++) begin
            exp_t = TAG_W'(1 + i);
            usr_tvalid = 1; usr_tuser = 1; usr_tlast = 1;
            #1;
            checks++; if (mac_ttag !== exp_t) begin failures++; $display("FAIL wrap_tag_%0d: got %0d required %0d", i, mac_ttag, exp_t); end
            step();
            usr_tvalid = 0; usr_tuser = 0; usr_tlast = 0;
            send_ret(exp_t, 80'(i));
            #1;
            checks++; if (ts_ttag !== exp_t || ts_tstatus !== 1'b0 || ts_tdata !== 80'(i)) begin
                failures++; $display("FAIL wrap_ts_%0d: tag %0d status %0b data %0h required %0d/0/%0h", i, ts_ttag, ts_tstatus, ts_tdata, exp_t, i); end
        end
        step();
        checks++; if (mismatch_cnt !== 1 || timeout_cnt !== 1 || outstanding !== 0) begin
            failures++; $display("FAIL wrap_end: mcnt %0d tcnt %0d outstanding %0d required 1/1/0", mismatch_cnt, timeout_cnt, outstanding); end
    endtask

    task automatic test_reset_mid();
        usr_tvalid = 1; usr_tuser = 1; usr_tlast = 0;
        #1;
        step();
        usr_tvalid = 0; usr_tuser = 0;
        #1;
        checks++; if (outstanding !== 1 || mac_ttag !== 4'd5) begin
            failures++; $display("FAIL rm_pre: outstanding %0d ttag %0d required 1/5", outstanding, mac_ttag); end
        resetn = 0;
        #1;
        checks++; if (outstanding !== 0 || mismatch_cnt !== 0 || timeout_cnt !== 0) begin
            failures++; $display("FAIL rm_counters: outstanding %0d mcnt %0d tcnt %0d required 0/0/0", outstanding, mismatch_cnt, timeout_cnt); end
        checks++; if (ts_tvalid !== 1'b0 || ts_ttag !== 0 || ts_tdata !== 80'h0 || mac_ttag !== 0) begin
            failures++; $display("FAIL rm_outputs: ts_tvalid %0b ts_tag %0d ts_data %0h mac_ttag %0d required 0/0/0/0",
                                 ts_tvalid, ts_ttag, ts_tdata, mac_ttag); end
        step();
        resetn = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_full();
        test_backpressure();
        test_match_vs_timeout();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

endmodule
